// File: rtl/hlsm_lane_datapath.sv
// hlsm_lane_datapath: scheduled five-step datapath applied to LANES independent
// (a,b,c) operand sets. Start launches a run from S_WAIT. Busy and Done are
// registered. Results z and x are registered and are valid from the Done cycle.
// Optional build macro: HLSM_LANE_ERROR_CHECK_EN adds ErrorRst/Error, a sticky
// flag for Start requests that arrive while the block is busy.

module hlsm_lane_datapath #(
  parameter int DATAW  = 32,
  parameter int LANES  = 1,
  parameter int SIGNED = 0
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Start,
`ifdef HLSM_LANE_ERROR_CHECK_EN
  input  logic                   ErrorRst,
  output logic                   Error,
`endif
  input  logic [LANES*DATAW-1:0] a,
  input  logic [LANES*DATAW-1:0] b,
  input  logic [LANES*DATAW-1:0] c,
  output logic                   Busy,
  output logic                   Done,
  output logic [LANES*DATAW-1:0] z,
  output logic [LANES*DATAW-1:0] x
);

  localparam int W = LANES * DATAW;

  typedef enum logic [2:0] {
    S_WAIT = 3'd0,
    S1     = 3'd1,
    S2     = 3'd2,
    S3     = 3'd3,
    S4     = 3'd4,
    S5     = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, c_q, c_d;
  logic [W-1:0]     d_q, d_d, e_q, e_d, f_q, f_d;
  logic [W-1:0]     g_q, g_d, h_q, h_d, xi_q, xi_d;
  logic [W-1:0]     z_q, z_d, x_q, x_d;
  logic [LANES-1:0] eq_q, eq_d, lt_q, lt_d;
  logic             busy_q, busy_d, done_q, done_d;

  // Next-state and per-step datapath logic; each step only updates its own registers
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    e_d     = e_q;
    f_d     = f_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    g_d     = g_q;
    h_d     = h_q;
    xi_d    = xi_q;
    z_d     = z_q;
    x_d     = x_q;

    case (state_q)
      S_WAIT: begin
        if (Start) begin
          a_d     = a;
          b_d     = b;
          c_d     = c;
          state_d = S1;
        end
      end
      S1: begin
        for (int i = 0; i < LANES; i++) begin
          d_d[i*DATAW +: DATAW] = a_q[i*DATAW +: DATAW] + b_q[i*DATAW +: DATAW];
          e_d[i*DATAW +: DATAW] = a_q[i*DATAW +: DATAW] + c_q[i*DATAW +: DATAW];
          f_d[i*DATAW +: DATAW] = a_q[i*DATAW +: DATAW] - b_q[i*DATAW +: DATAW];
        end
        state_d = S2;
      end
      S2: begin
        for (int i = 0; i < LANES; i++) begin
          eq_d[i] = (d_q[i*DATAW +: DATAW] == e_q[i*DATAW +: DATAW]);
          if (SIGNED != 0) begin
            lt_d[i] = ($signed(d_q[i*DATAW +: DATAW]) < $signed(e_q[i*DATAW +: DATAW]));
          end else begin
            lt_d[i] = (d_q[i*DATAW +: DATAW] < e_q[i*DATAW +: DATAW]);
          end
        end
        state_d = S3;
      end
      S3: begin
        for (int i = 0; i < LANES; i++) begin
          g_d[i*DATAW +: DATAW] = lt_q[i] ? d_q[i*DATAW +: DATAW] : e_q[i*DATAW +: DATAW];
        end
        state_d = S4;
      end
      S4: begin
        for (int i = 0; i < LANES; i++) begin
          h_d[i*DATAW +: DATAW]  = eq_q[i] ? g_q[i*DATAW +: DATAW] : f_q[i*DATAW +: DATAW];
          xi_d[i*DATAW +: DATAW] = g_q[i*DATAW +: DATAW] << lt_q[i];
        end
        state_d = S5;
      end
      S5: begin
        for (int i = 0; i < LANES; i++) begin
          // The arithmetic shift is kept in its own statement so the signed
          // operand is not demoted to unsigned by a surrounding expression.
          if (SIGNED != 0) begin
            z_d[i*DATAW +: DATAW] = $signed(h_q[i*DATAW +: DATAW]) >>> eq_q[i];
          end else begin
            z_d[i*DATAW +: DATAW] = h_q[i*DATAW +: DATAW] >> eq_q[i];
          end
        end
        x_d     = xi_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_WAIT;
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase

    busy_d = (state_d != S_WAIT);
    done_d = (state_d == S_DONE);
  end

  // State, operand, schedule and output registers; synchronous reset aborts any run
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_WAIT;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      e_q     <= '0;
      f_q     <= '0;
      eq_q    <= '0;
      lt_q    <= '0;
      g_q     <= '0;
      h_q     <= '0;
      xi_q    <= '0;
      z_q     <= '0;
      x_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      e_q     <= e_d;
      f_q     <= f_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      g_q     <= g_d;
      h_q     <= h_d;
      xi_q    <= xi_d;
      z_q     <= z_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign z    = z_q;
  assign x    = x_q;

`ifdef HLSM_LANE_ERROR_CHECK_EN
  logic error_q, error_d;

  // Sticky error: a Start while busy sets it and beats a concurrent ErrorRst
  always_comb begin
    error_d = error_q;
    if (Start && busy_q) begin
      error_d = 1'b1;
    end else if (ErrorRst) begin
      error_d = 1'b0;
    end
  end

  // Error flag register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign Error = error_q;
`endif

endmodule

// File: tb/tb_hlsm_lane_datapath.sv
// Directed testbench for hlsm_lane_datapath. Three instances share Clk/Rst:
// an 8-bit single-lane unsigned one, plus 2-lane signed and unsigned ones.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_hlsm_lane_datapath;

  logic        Clk;
  logic        Rst;
  logic        err_rst;

  logic        start0;
  logic [7:0]  a0, b0, c0;
  logic        busy0, done0;
  logic [7:0]  z0, x0;

  logic        start_l;
  logic [15:0] a_l, b_l, c_l;
  logic        busy1, done1, busy2, done2;
  logic [15:0] z1, x1, z2, x2;

`ifdef HLSM_LANE_ERROR_CHECK_EN
  logic        err0, err1, err2;
`endif

  int checks = 0;
  int fails  = 0;

  hlsm_lane_datapath #(.DATAW(8), .LANES(1), .SIGNED(0)) dut0 (
    .Clk(Clk), .Rst(Rst), .Start(start0),
`ifdef HLSM_LANE_ERROR_CHECK_EN
    .ErrorRst(err_rst), .Error(err0),
`endif
    .a(a0), .b(b0), .c(c0), .Busy(busy0), .Done(done0), .z(z0), .x(x0)
  );

  hlsm_lane_datapath #(.DATAW(8), .LANES(2), .SIGNED(1)) dut1 (
    .Clk(Clk), .Rst(Rst), .Start(start_l),
`ifdef HLSM_LANE_ERROR_CHECK_EN
    .ErrorRst(err_rst), .Error(err1),
`endif
    .a(a_l), .b(b_l), .c(c_l), .Busy(busy1), .Done(done1), .z(z1), .x(x1)
  );

  hlsm_lane_datapath #(.DATAW(8), .LANES(2), .SIGNED(0)) dut2 (
    .Clk(Clk), .Rst(Rst), .Start(start_l),
`ifdef HLSM_LANE_ERROR_CHECK_EN
    .ErrorRst(err_rst), .Error(err2),
`endif
    .a(a_l), .b(b_l), .c(c_l), .Busy(busy2), .Done(done2), .z(z2), .x(x2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Pulse Start on dut0 for one edge, then scramble the operands.
  task automatic start_dut0(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] cv);
    @(negedge Clk);
    a0 = av; b0 = bv; c0 = cv; start0 = 1'b1;
    @(negedge Clk);
    start0 = 1'b0; a0 = ~av; b0 = 8'h5A; c0 = cv + 8'd7;
  endtask

  // Bounded wait for done0; cyc counts falling edges since the Start edge.
  task automatic wait_done0(input int from, output int cyc);
    cyc = from;
    while (done0 !== 1'b1 && cyc < 20) begin
      @(negedge Clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    checks++; if (busy0 !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy0); end
    checks++; if (done0 !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done0); end
    checks++; if (z0 !== 8'h00) begin fails++; $display("[TB] FAIL reset_z: got %h expected 00", z0); end
    checks++; if (x0 !== 8'h00) begin fails++; $display("[TB] FAIL reset_x: got %h expected 00", x0); end
    checks++; if (z1 !== 16'h0000 || x2 !== 16'h0000) begin fails++; $display("[TB] FAIL reset_lanes: got z1=%h x2=%h expected 0000", z1, x2); end
`ifdef HLSM_LANE_ERROR_CHECK_EN
    checks++; if (err0 !== 1'b0) begin fails++; $display("[TB] FAIL reset_error: got %b expected 0", err0); end
`endif
    Rst = 1'b0;
  endtask

  task automatic test_latency();
    int busy_cnt;
    busy_cnt = 0;
    start_dut0(8'd5, 8'd3, 8'd1);
    // k = falling edges since the Start edge; Done expected only at k == 6
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) @(negedge Clk);
      if (busy0 === 1'b1) busy_cnt++;
      checks++;
      if (done0 !== (k == 6)) begin fails++; $display("[TB] FAIL latency_done k=%0d: got %b expected %b", k, done0, (k == 6)); end
      if (k < 6) begin
        checks++;
        if (z0 !== 8'h00) begin fails++; $display("[TB] FAIL early_z k=%0d: got %h expected 00", k, z0); end
      end
      if (k == 6) begin
        // d=8 e=6 f=2, eq=0 lt=0 -> g=6 h=2, z=2 x=6
        checks++; if (z0 !== 8'd2) begin fails++; $display("[TB] FAIL basic_z: got %0d expected 2", z0); end
        checks++; if (x0 !== 8'd6) begin fails++; $display("[TB] FAIL basic_x: got %0d expected 6", x0); end
      end
    end
    checks++;
    if (busy_cnt != 6) begin fails++; $display("[TB] FAIL busy_cycles: got %0d expected 6", busy_cnt); end
  endtask

  task automatic test_patterns();
    int cyc;
    // d=e=3 f=255: eq=1 lt=0 -> g=3 h=3 x=3 z=1
    start_dut0(8'd1, 8'd2, 8'd2);
    wait_done0(1, cyc);
    checks++; if (cyc != 6) begin fails++; $display("[TB] FAIL eq_latency: got %0d expected 6", cyc); end
    checks++; if (z0 !== 8'd1) begin fails++; $display("[TB] FAIL eq_z: got %0d expected 1", z0); end
    checks++; if (x0 !== 8'd3) begin fails++; $display("[TB] FAIL eq_x: got %0d expected 3", x0); end
    @(negedge Clk);
    checks++; if (done0 !== 1'b0 || z0 !== 8'd1) begin fails++; $display("[TB] FAIL hold: got done=%b z=%0d expected done=0 z=1", done0, z0); end
    // d=1 e=4 f=255: eq=0 lt=1 -> g=1 h=255 x=2 z=255
    start_dut0(8'd0, 8'd1, 8'd4);
    wait_done0(1, cyc);
    checks++; if (cyc != 6) begin fails++; $display("[TB] FAIL lt_latency: got %0d expected 6", cyc); end
    checks++; if (z0 !== 8'd255) begin fails++; $display("[TB] FAIL lt_z: got %0d expected 255", z0); end
    checks++; if (x0 !== 8'd2) begin fails++; $display("[TB] FAIL lt_x: got %0d expected 2", x0); end
  endtask

  task automatic test_lanes();
    int cyc;
    @(negedge Clk);
    a_l = {8'd200, 8'd0}; b_l = {8'd100, 8'hFF}; c_l = {8'd0, 8'd1}; start_l = 1'b1;
    @(negedge Clk);
    start_l = 1'b0; a_l = 16'h1234; b_l = 16'hABCD; c_l = 16'h0F0F;
    cyc = 1;
    while (done1 !== 1'b1 && cyc < 20) begin @(negedge Clk); cyc++; end
    checks++; if (cyc != 6) begin fails++; $display("[TB] FAIL lanes_latency: got %0d expected 6", cyc); end
    checks++; if (done2 !== 1'b1) begin fails++; $display("[TB] FAIL lanes_done_u: got %b expected 1", done2); end
    // lane0 signed: d=-1 < e=1 -> g=FF, x=FE, h=f=1, z=1
    // lane1 (d=44 e=200 f=100) signed: lt=0 -> g=C8 x=C8, z=64
    checks++; if (z1 !== 16'h6401) begin fails++; $display("[TB] FAIL lanes_signed_z: got %h expected 6401", z1); end
    checks++; if (x1 !== 16'hC8FE) begin fails++; $display("[TB] FAIL lanes_signed_x: got %h expected c8fe", x1); end
    // lane0 unsigned: lt=0 -> g=1, x=1, z=1
    // lane1 unsigned: 44 < 200 -> g=2C, x=58, h=f=64, z=64
    checks++; if (z2 !== 16'h6401) begin fails++; $display("[TB] FAIL lanes_unsigned_z: got %h expected 6401", z2); end
    checks++; if (x2 !== 16'h5801) begin fails++; $display("[TB] FAIL lanes_unsigned_x: got %h expected 5801", x2); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    @(negedge Clk);
    a0 = 8'd5; b0 = 8'd3; c0 = 8'd1; start0 = 1'b1;
    // cyc-1 = index of the last rising edge; runs latch at edges 0, 7, 14
    for (int cyc = 1; cyc <= 21; cyc++) begin
      @(negedge Clk);
      if (cyc == 1) begin a0 = 8'd1; b0 = 8'd2; c0 = 8'd2; end
      if (cyc == 8) begin a0 = 8'd0; b0 = 8'd1; c0 = 8'd4; end
      if (cyc == 20) start0 = 1'b0;
      if (done0 === 1'b1) pulses++;
      checks++;
      if (done0 !== (cyc == 6 || cyc == 13 || cyc == 20)) begin
        fails++; $display("[TB] FAIL b2b_done cyc=%0d: got %b", cyc, done0);
      end
      if (cyc == 6) begin
        checks++; if (z0 !== 8'd2 || x0 !== 8'd6) begin fails++; $display("[TB] FAIL b2b_run1: got z=%0d x=%0d expected z=2 x=6", z0, x0); end
      end
      if (cyc == 13) begin
        checks++; if (z0 !== 8'd1 || x0 !== 8'd3) begin fails++; $display("[TB] FAIL b2b_run2: got z=%0d x=%0d expected z=1 x=3", z0, x0); end
      end
      if (cyc == 20) begin
        checks++; if (z0 !== 8'd255 || x0 !== 8'd2) begin fails++; $display("[TB] FAIL b2b_run3: got z=%0d x=%0d expected z=255 x=2", z0, x0); end
      end
    end
    checks++;
    if (pulses != 3) begin fails++; $display("[TB] FAIL b2b_pulses: got %0d expected 3", pulses); end
  endtask

  task automatic test_reset_abort();
    int cyc;
    int seen;
    seen = 0;
    start_dut0(8'd5, 8'd3, 8'd1);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin fails++; $display("[TB] FAIL abort_flags: got busy=%b done=%b expected 0 0", busy0, done0); end
    checks++; if (z0 !== 8'h00 || x0 !== 8'h00) begin fails++; $display("[TB] FAIL abort_outputs: got z=%h x=%h expected 00 00", z0, x0); end
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      if (done0 === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin fails++; $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", seen); end
    start_dut0(8'd1, 8'd2, 8'd2);
    wait_done0(1, cyc);
    checks++; if (cyc != 6 || z0 !== 8'd1 || x0 !== 8'd3) begin fails++; $display("[TB] FAIL abort_rerun: got cyc=%0d z=%0d x=%0d expected 6 1 3", cyc, z0, x0); end
  endtask

`ifdef HLSM_LANE_ERROR_CHECK_EN
  task automatic test_error();
    int cyc;
    start_dut0(8'd5, 8'd3, 8'd1);
    @(negedge Clk);
    start0 = 1'b1;
    @(negedge Clk);
    start0 = 1'b0;
    checks++; if (err0 !== 1'b1) begin fails++; $display("[TB] FAIL err_set: got %b expected 1", err0); end
    wait_done0(3, cyc);
    checks++; if (cyc != 6 || z0 !== 8'd2 || x0 !== 8'd6) begin fails++; $display("[TB] FAIL err_run: got cyc=%0d z=%0d x=%0d expected 6 2 6", cyc, z0, x0); end
    start_dut0(8'd0, 8'd1, 8'd4);
    @(negedge Clk);
    start0 = 1'b1; err_rst = 1'b1;
    @(negedge Clk);
    start0 = 1'b0; err_rst = 1'b0;
    checks++; if (err0 !== 1'b1) begin fails++; $display("[TB] FAIL err_priority: got %b expected 1", err0); end
    wait_done0(3, cyc);
    checks++; if (cyc != 6 || z0 !== 8'd255 || x0 !== 8'd2) begin fails++; $display("[TB] FAIL err_run2: got cyc=%0d z=%0d x=%0d expected 6 255 2", cyc, z0, x0); end
    @(negedge Clk);
    err_rst = 1'b1;
    @(negedge Clk);
    err_rst = 1'b0;
    checks++; if (err0 !== 1'b0) begin fails++; $display("[TB] FAIL err_clear: got %b expected 0", err0); end
  endtask
`endif

  initial begin
    Rst = 1'b1; err_rst = 1'b0;
    start0 = 1'b0; a0 = '0; b0 = '0; c0 = '0;
    start_l = 1'b0; a_l = '0; b_l = '0; c_l = '0;
    test_reset();
    test_latency();
    test_patterns();
    test_lanes();
    test_back_to_back();
    test_reset_abort();
`ifdef HLSM_LANE_ERROR_CHECK_EN
    test_error();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
